// File: rtl/quad_counter.sv
// quad_counter: quadrature rotary-encoder front end.
//
// Takes the raw, asynchronous A/B encoder pins. Each pin passes through a
// 2-FF synchroniser and a per-bit hold-time filter. Steps are decoded from
// changes of the filtered pair, and an up/down position counter is kept.
//
// Parameters
//   WIDTH    : position counter width (>= 2)
//   FILTER   : cycles a synchronised bit must hold a new value before it is
//              accepted (>= 1)
//   X4       : 0 = one count per full detent, 1 = one count per valid edge
//   SATURATE : 0 = counter wraps, 1 = counter clamps at 0 / 2^WIDTH-1
//
// Ports
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   a, b   in   raw encoder channels (asynchronous)
//   clear  in   synchronous counter clear (wins over a simultaneous step)
//   count  out  unsigned position, WIDTH bits
//   cw     out  one-cycle pulse per clockwise step
//   ccw    out  one-cycle pulse per counter-clockwise step
//   error  out  one-cycle pulse on an illegal (double-bit) transition
module quad_counter #(
  parameter int WIDTH    = 8,
  parameter int FILTER   = 4,
  parameter int X4       = 0,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             cw,
  output logic             ccw,
  output logic             error
);

  localparam int FCW = (FILTER < 2) ? 1 : $clog2(FILTER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CW_A,
    S_CW_B,
    S_CW_C,
    S_CCW_A,
    S_CCW_B,
    S_CCW_C
  } state_t;

  // Front end: synchroniser, filter, decode history
  logic [1:0]     r_sync1;
  logic [1:0]     r_sync2;
  logic [1:0]     r_filt;
  logic [1:0]     r_prev;
  logic [FCW-1:0] r_fcnt [2];
  logic [1:0]     r_live;
  logic           r_armed;

  // Decode / output state
  state_t         r_state;
  state_t         w_state_next;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic           r_cw;
  logic           r_ccw;
  logic           r_err;
  logic           w_step_cw;
  logic           w_step_ccw;
  logic           w_err;
  logic           w_change;
  logic           w_double;

  // Synchroniser and per-bit filter. Bit 1 is A, bit 0 is B.
  // r_live marks that the synchroniser has flushed its reset preset, so
  // arming only happens once the real pins are seen at 11. This keeps a
  // reset taken with the pins away from 11 from producing a spurious error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
      r_filt  <= 2'b11;
      r_prev  <= 2'b11;
      r_live  <= '0;
      r_armed <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_fcnt[i] <= '0;
      end
    end else begin
      r_sync1 <= {a, b};
      r_sync2 <= r_sync1;
      r_prev  <= r_filt;
      r_live  <= {r_live[0], 1'b1};
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_filt[i]) begin
          // The FILTER-th consecutive differing sample is accepted.
          if (r_fcnt[i] == FCW'(FILTER - 1)) begin
            r_filt[i] <= r_sync2[i];
            r_fcnt[i] <= '0;
          end else begin
            r_fcnt[i] <= r_fcnt[i] + FCW'(1);
          end
        end else begin
          r_fcnt[i] <= '0;
        end
      end
      if (r_live[1] && (r_filt == 2'b11) && (r_sync2 == 2'b11)) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_change = (r_filt != r_prev);
  assign w_double = &(r_filt ^ r_prev);

  // Step / error decode and detent FSM next state.
  always_comb begin
    w_state_next = r_state;
    w_step_cw    = 1'b0;
    w_step_ccw   = 1'b0;
    w_err        = 1'b0;
    if (!r_armed) begin
      w_state_next = S_IDLE;
    end else if (w_change) begin
      if (w_double) begin
        w_err        = 1'b1;
        w_state_next = S_IDLE;
      end else if (X4 != 0) begin
        // Single-bit changes are either a forward or a reverse edge.
        case ({r_prev, r_filt})
          4'b1101, 4'b0100, 4'b0010, 4'b1011: w_step_cw  = 1'b1;
          default:                            w_step_ccw = 1'b1;
        endcase
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_filt == 2'b01)      w_state_next = S_CW_A;
            else if (r_filt == 2'b10) w_state_next = S_CCW_A;
          end
          S_CW_A: begin
            if (r_filt == 2'b00)      w_state_next = S_CW_B;
            else if (r_filt == 2'b11) w_state_next = S_IDLE;
          end
          S_CW_B: begin
            if (r_filt == 2'b01)      w_state_next = S_CW_A;
            else if (r_filt == 2'b10) w_state_next = S_CW_C;
          end
          S_CW_C: begin
            if (r_filt == 2'b00) begin
              w_state_next = S_CW_B;
            end else if (r_filt == 2'b11) begin
              w_state_next = S_IDLE;
              w_step_cw    = 1'b1;
            end
          end
          S_CCW_A: begin
            if (r_filt == 2'b00)      w_state_next = S_CCW_B;
            else if (r_filt == 2'b11) w_state_next = S_IDLE;
          end
          S_CCW_B: begin
            if (r_filt == 2'b10)      w_state_next = S_CCW_A;
            else if (r_filt == 2'b01) w_state_next = S_CCW_C;
          end
          S_CCW_C: begin
            if (r_filt == 2'b00) begin
              w_state_next = S_CCW_B;
            end else if (r_filt == 2'b11) begin
              w_state_next = S_IDLE;
              w_step_ccw   = 1'b1;
            end
          end
          default: w_state_next = S_IDLE;
        endcase
      end
    end
  end

  // Position update: clear has priority; saturation holds at the limits.
  always_comb begin
    w_count_next = r_count;
    if (clear) begin
      w_count_next = '0;
    end else if (w_step_cw) begin
      if (!((SATURATE != 0) && (r_count == '1))) begin
        w_count_next = r_count + WIDTH'(1);
      end
    end else if (w_step_ccw) begin
      if (!((SATURATE != 0) && (r_count == '0))) begin
        w_count_next = r_count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_cw    <= 1'b0;
      r_ccw   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_cw    <= w_step_cw;
      r_ccw   <= w_step_ccw;
      r_err   <= w_err;
    end
  end

  assign count = r_count;
  assign cw    = r_cw;
  assign ccw   = r_ccw;
  assign error = r_err;

endmodule

// File: tb/tb_quad_counter.sv
// Bench for quad_counter: four instances (x1 wrap, x4 wrap, 4-bit wrap,
// 4-bit saturate) share the same pin stimulus. A phase-arithmetic reference
// model is compared every cycle; directed table rows and hand sequences
// cover latency, glitches, errors, wrap/saturate, clear and mid-run reset.
module tb_quad_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b1;
  logic b = 1'b1;
  logic clear = 1'b0;
  logic [7:0] c0, c1;
  logic [3:0] c2, c3;
  logic [3:0] o_cw, o_ccw, o_err;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  quad_counter #(.WIDTH(8), .FILTER(4), .X4(0), .SATURATE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clear(clear),
    .count(c0), .cw(o_cw[0]), .ccw(o_ccw[0]), .error(o_err[0]));
  quad_counter #(.WIDTH(8), .FILTER(4), .X4(1), .SATURATE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clear(clear),
    .count(c1), .cw(o_cw[1]), .ccw(o_ccw[1]), .error(o_err[1]));
  quad_counter #(.WIDTH(4), .FILTER(4), .X4(0), .SATURATE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clear(clear),
    .count(c2), .cw(o_cw[2]), .ccw(o_ccw[2]), .error(o_err[2]));
  quad_counter #(.WIDTH(4), .FILTER(4), .X4(0), .SATURATE(1)) u3 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clear(clear),
    .count(c3), .cw(o_cw[3]), .ccw(o_ccw[3]), .error(o_err[3]));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int dcount(input int i);
    case (i)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      default: return int'(c3);
    endcase
  endfunction

  function automatic int pw(input int i);
    return (i < 2) ? 8 : 4;
  endfunction

  // Gray position: 11 -> 0, 01 -> 1, 00 -> 2, 10 -> 3 (clockwise increasing)
  function automatic int ph(input bit [1:0] v);
    case (v)
      2'b11: return 0;
      2'b01: return 1;
      2'b00: return 2;
      default: return 3;
    endcase
  endfunction

  // ---------------- reference model ----------------
  localparam int F = 4;
  bit [1:0] ms1, ms2, mfilt, mprev;
  bit [1:0] win [F];
  int nedge;
  bit marm;
  bit mvalid = 1'b0;
  int acc [4];
  int mcnt [4];
  bit mcw [4], mccw [4], merr [4];

  task automatic model_step();
    int d, maxv;
    bit [1:0] old;
    bit all;
    if (!rst_n) begin
      ms1 = 2'b11; ms2 = 2'b11; mfilt = 2'b11; mprev = 2'b11;
      for (int j = 0; j < F; j++) win[j] = 2'b11;
      nedge = 0;
      marm = 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc[i] = 0; mcnt[i] = 0; mcw[i] = 0; mccw[i] = 0; merr[i] = 0;
      end
      mvalid = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        mcw[i] = 0; mccw[i] = 0; merr[i] = 0;
        if (marm && (mprev != mfilt)) begin
          d = (ph(mfilt) - ph(mprev) + 4) % 4;
          if (d == 2) begin
            merr[i] = 1; acc[i] = 0;
          end else if (i == 1) begin
            if (d == 1) mcw[i] = 1; else mccw[i] = 1;
          end else if (acc[i] == 0) begin
            if (mfilt == 2'b01) acc[i] = 1;
            else if (mfilt == 2'b10) acc[i] = -1;
          end else begin
            acc[i] += (d == 1) ? 1 : -1;
            if (acc[i] == 4) begin mcw[i] = 1; acc[i] = 0; end
            else if (acc[i] == -4) begin mccw[i] = 1; acc[i] = 0; end
          end
        end
        maxv = (1 << pw(i)) - 1;
        if (clear) mcnt[i] = 0;
        else if (mcw[i]) mcnt[i] = (mcnt[i] == maxv) ? ((i == 3) ? maxv : 0) : mcnt[i] + 1;
        else if (mccw[i]) mcnt[i] = (mcnt[i] == 0) ? ((i == 3) ? 0 : maxv) : mcnt[i] - 1;
      end
      if (nedge >= 2 && mfilt == 2'b11 && ms2 == 2'b11) marm = 1'b1;
      old = mfilt;
      for (int j = F - 1; j > 0; j--) win[j] = win[j-1];
      win[0] = ms2;
      for (int k = 0; k < 2; k++) begin
        all = 1'b1;
        for (int j = 0; j < F; j++) if (win[j][k] == mfilt[k]) all = 1'b0;
        if (all) mfilt[k] = ~mfilt[k];
      end
      mprev = old;
      ms2 = ms1;
      ms1 = {a, b};
      nedge++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("u%0d.count", i), dcount(i), mcnt[i]);
        chk($sformatf("u%0d.cw", i), int'(o_cw[i]), int'(mcw[i]));
        chk($sformatf("u%0d.ccw", i), int'(o_ccw[i]), int'(mccw[i]));
        chk($sformatf("u%0d.error", i), int'(o_err[i]), int'(merr[i]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int t_cw [4], t_ccw [4], t_err [4];

  task automatic clr_tally();
    for (int i = 0; i < 4; i++) begin t_cw[i] = 0; t_ccw[i] = 0; t_err[i] = 0; end
  endtask

  task automatic hold(input bit [1:0] ab, input int n);
    {a, b} = ab;
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        t_cw[i]  += int'(o_cw[i]);
        t_ccw[i] += int'(o_ccw[i]);
        t_err[i] += int'(o_err[i]);
      end
    end
  endtask

  task automatic do_reset(input bit [1:0] ab);
    rst_n = 1'b0;
    hold(ab, 3);
    rst_n = 1'b1;
    hold(ab, 5);
  endtask

  task automatic detent(input bit dir_cw, input int n);
    if (dir_cw) begin
      hold(2'b01, n); hold(2'b00, n); hold(2'b10, n); hold(2'b11, n);
    end else begin
      hold(2'b10, n); hold(2'b00, n); hold(2'b01, n); hold(2'b11, n);
    end
  endtask

  typedef struct {
    bit [1:0] ab;
    int hold;
    int cw0, ccw0, err0, cnt0;
    int cw1, ccw1, err1, cnt1;
  } row_t;

  row_t tbl [16];
  int lat;
  int p;
  bit [1:0] pins;

  initial begin
    // ab, hold, u0{cw,ccw,err,count}, u1{cw,ccw,err,count}
    tbl[0]  = '{2'b01, 10, 0, 0, 0, 0, 1, 0, 0, 1};
    tbl[1]  = '{2'b00, 10, 0, 0, 0, 0, 1, 0, 0, 2};
    tbl[2]  = '{2'b10, 10, 0, 0, 0, 0, 1, 0, 0, 3};
    tbl[3]  = '{2'b11, 10, 1, 0, 0, 1, 1, 0, 0, 4};
    tbl[4]  = '{2'b10, 10, 0, 0, 0, 1, 0, 1, 0, 3};
    tbl[5]  = '{2'b00, 10, 0, 0, 0, 1, 0, 1, 0, 2};
    tbl[6]  = '{2'b01, 10, 0, 0, 0, 1, 0, 1, 0, 1};
    tbl[7]  = '{2'b11, 10, 0, 1, 0, 0, 0, 1, 0, 0};
    tbl[8]  = '{2'b01,  3, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{2'b11, 10, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{2'b00, 10, 0, 0, 1, 0, 0, 0, 1, 0};
    tbl[11] = '{2'b11, 10, 0, 0, 1, 0, 0, 0, 1, 0};
    tbl[12] = '{2'b01, 10, 0, 0, 0, 0, 1, 0, 0, 1};
    tbl[13] = '{2'b00, 10, 0, 0, 0, 0, 1, 0, 0, 2};
    tbl[14] = '{2'b10, 10, 0, 0, 0, 0, 1, 0, 0, 3};
    tbl[15] = '{2'b11, 10, 1, 0, 0, 1, 1, 0, 0, 4};

    @(negedge clk);
    rst_n = 1'b0;
    hold(2'b11, 3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset u%0d.count", i), dcount(i), 0);
      chk($sformatf("reset u%0d.pulses", i), int'(o_cw[i]) + int'(o_ccw[i]) + int'(o_err[i]), 0);
    end
    rst_n = 1'b1;
    hold(2'b11, 10);

    for (int r = 0; r < 16; r++) begin
      clr_tally();
      hold(tbl[r].ab, tbl[r].hold);
      chk($sformatf("row%0d u0.cw", r),    t_cw[0],  tbl[r].cw0);
      chk($sformatf("row%0d u0.ccw", r),   t_ccw[0], tbl[r].ccw0);
      chk($sformatf("row%0d u0.err", r),   t_err[0], tbl[r].err0);
      chk($sformatf("row%0d u0.count", r), int'(c0), tbl[r].cnt0);
      chk($sformatf("row%0d u1.cw", r),    t_cw[1],  tbl[r].cw1);
      chk($sformatf("row%0d u1.ccw", r),   t_ccw[1], tbl[r].ccw1);
      chk($sformatf("row%0d u1.err", r),   t_err[1], tbl[r].err1);
      chk($sformatf("row%0d u1.count", r), int'(c1), tbl[r].cnt1);
    end

    // Pin edge to cw pulse: 3 + FILTER clocks.
    hold(2'b01, 10); hold(2'b00, 10); hold(2'b10, 10);
    {a, b} = 2'b11;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (o_cw[0] && lat < 0) lat = k;
    end
    chk("latency", lat, 7);
    chk("latency count", int'(c0), 2);

    // Wrap vs saturate on 4-bit counters.
    do_reset(2'b11);
    hold(2'b11, 5);
    for (int k = 0; k < 15; k++) detent(1'b1, 8);
    chk("15 detents u2.count", int'(c2), 15);
    chk("15 detents u3.count", int'(c3), 15);
    clr_tally();
    detent(1'b1, 8);
    chk("16th u2.count wrap", int'(c2), 0);
    chk("16th u3.count sat", int'(c3), 15);
    chk("16th u3.cw pulse", t_cw[3], 1);
    do_reset(2'b11);
    hold(2'b11, 5);
    clr_tally();
    detent(1'b0, 8);
    chk("ccw u3.count sat", int'(c3), 0);
    chk("ccw u3.ccw pulse", t_ccw[3], 1);
    chk("ccw u2.count wrap", int'(c2), 15);

    // Clear coinciding with a cw pulse.
    do_reset(2'b11);
    hold(2'b11, 5);
    for (int k = 0; k < 5; k++) detent(1'b1, 8);
    chk("pre-clear u0.count", int'(c0), 5);
    hold(2'b01, 8); hold(2'b00, 8); hold(2'b10, 8);
    hold(2'b11, 6);
    clear = 1'b1;
    @(negedge clk);
    chk("clear u0.cw", int'(o_cw[0]), 1);
    chk("clear u0.count", int'(c0), 0);
    clear = 1'b0;
    hold(2'b11, 10);

    // Reset in the middle of a detent, released with pins at 00.
    hold(2'b01, 8); hold(2'b00, 8);
    rst_n = 1'b0;
    hold(2'b00, 3);
    rst_n = 1'b1;
    clr_tally();
    hold(2'b00, 20);
    hold(2'b11, 12);
    chk("midreset u0.err", t_err[0], 0);
    chk("midreset u1.err", t_err[1], 0);
    chk("midreset u0.count", int'(c0), 0);
    chk("midreset u1.count", int'(c1), 0);
    clr_tally();
    detent(1'b1, 8);
    chk("post-reset u0.count", int'(c0), 1);
    chk("post-reset u0.cw", t_cw[0], 1);

    // Random walk with glitches, jumps, clears and resets.
    p = 0;
    for (int s = 0; s < 400; s++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: p = (p + 1) % 4;
        4, 5, 6, 7: p = (p + 3) % 4;
        default:    p = $urandom_range(0, 3);
      endcase
      case (p)
        0: pins = 2'b11;
        1: pins = 2'b01;
        2: pins = 2'b00;
        default: pins = 2'b10;
      endcase
      clear = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 1'b0;
        hold(pins, 2);
        rst_n = 1'b1;
      end
      hold(pins, $urandom_range(1, 9));
      clear = 1'b0;
    end
    hold(2'b11, 10);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
